// File: rtl/pacman_pkg.sv
// Shared Pac-Man definitions: tile coordinate widths, game state encoding,
// and a tile comparison helper used by the collision logic.
package pacman_pkg;

    localparam int X_W = 6;
    localparam int Y_W = 5;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        PLAY     = 3'd1,
        RESUME   = 3'd2,
        LEVEL_UP = 3'd3,
        OVER     = 3'd4,
        WIN      = 3'd5
    } game_state_t;

    // Two sprites collide when they occupy the same tile.
    function automatic logic tile_match(
        input logic [X_W-1:0] ax,
        input logic [Y_W-1:0] ay,
        input logic [X_W-1:0] bx,
        input logic [Y_W-1:0] by
    );
        return (ax == bx) && (ay == by);
    endfunction

endpackage

// File: rtl/freeze_timer.sv
// Freeze countdown for the RESUME and LEVEL_UP pauses. Loading N-1 makes
// done rise after N clocks, so the caller stays frozen for exactly N cycles.
module freeze_timer #(
    parameter int WIDTH = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_r;

    // Load on request, otherwise count down and rest at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {WIDTH{1'b0}}) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: start/death/level/win sequencing, lives and dot
// bookkeeping, ghost collision detection and sprite/map control strobes.
module game_flow_ctrl
    import pacman_pkg::*;
#(
    parameter int NUM_GHOSTS    = 4,
    parameter int LIVES_INIT    = 3,
    parameter int RESUME_CYCLES = 250000000,
    parameter int LEVEL_CYCLES  = 100000000,
    parameter int DOT_TARGET    = 309,
    parameter int MAX_LEVEL     = 4
) (
    input  logic                             CLOCK_50,
    input  logic                             reset,
    input  logic                             start,
    input  logic [X_W-1:0]                   pacman_x,
    input  logic [Y_W-1:0]                   pacman_y,
    input  logic [NUM_GHOSTS-1:0][X_W-1:0]   ghost_x,
    input  logic [NUM_GHOSTS-1:0][Y_W-1:0]   ghost_y,
    input  logic                             power_active,
    input  logic                             dot_eaten,
    output game_state_t                      state,
    output logic [2:0]                       lives,
    output logic [2:0]                       level,
    output logic [9:0]                       dot_count,
    output logic                             sprite_reset,
    output logic                             map_reload,
    output logic                             ghost_enable,
    output logic                             life_lost,
    output logic [NUM_GHOSTS-1:0]            ghost_eaten
);

    localparam int MAX_FREEZE = (RESUME_CYCLES > LEVEL_CYCLES) ? RESUME_CYCLES : LEVEL_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_FREEZE + 1);
    localparam logic [TIMER_W-1:0] RESUME_LOAD = TIMER_W'(RESUME_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LEVEL_LOAD  = TIMER_W'(LEVEL_CYCLES - 1);
    localparam logic [9:0]         DOT_TGT     = 10'(DOT_TARGET);
    localparam logic [2:0]         LIVES_LD    = 3'(LIVES_INIT);
    localparam logic [2:0]         LEVEL_LAST  = 3'(MAX_LEVEL);

    game_state_t           state_r, state_nxt_s;
    logic [2:0]            lives_r, lives_nxt_s;
    logic [2:0]            level_r, level_nxt_s;
    logic [9:0]            dot_r, dot_nxt_s;
    logic                  life_lost_r, life_lost_nxt_s;
    logic [NUM_GHOSTS-1:0] ghost_eaten_r, ghost_eaten_nxt_s;
    logic                  sprite_reset_r, map_reload_r, ghost_enable_r;
    logic                  start_r;
    logic [NUM_GHOSTS-1:0] hit_s, hit_r;
    logic                  start_rise_s, lethal_s;
    logic                  timer_load_s, timer_done_s;
    logic [TIMER_W-1:0]    timer_val_s;

    // Per-ghost tile collision with pacman.
    always_comb begin
        hit_s = {NUM_GHOSTS{1'b0}};
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            hit_s[i] = tile_match(ghost_x[i], ghost_y[i], pacman_x, pacman_y);
        end
    end

    assign start_rise_s = start & ~start_r;
    assign lethal_s     = (|hit_s) & ~power_active;

    freeze_timer #(
        .WIDTH (TIMER_W)
    ) u_freeze_timer (
        .clk      (CLOCK_50),
        .rst      (reset),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .done     (timer_done_s)
    );

    // Next-state, bookkeeping and pulse decisions.
    always_comb begin
        state_nxt_s       = state_r;
        lives_nxt_s       = lives_r;
        level_nxt_s       = level_r;
        dot_nxt_s         = dot_r;
        life_lost_nxt_s   = 1'b0;
        ghost_eaten_nxt_s = {NUM_GHOSTS{1'b0}};
        timer_load_s      = 1'b0;
        timer_val_s       = {TIMER_W{1'b0}};
        case (state_r)
            INIT: begin
                if (start) begin
                    state_nxt_s = PLAY;
                    lives_nxt_s = LIVES_LD;
                    level_nxt_s = 3'd1;
                    dot_nxt_s   = 10'd0;
                end else begin
                    state_nxt_s = INIT;
                end
            end
            PLAY: begin
                if (power_active) begin
                    ghost_eaten_nxt_s = hit_s & ~hit_r;
                end else begin
                    ghost_eaten_nxt_s = {NUM_GHOSTS{1'b0}};
                end
                // A death outranks level completion; that dot is dropped.
                if (lethal_s) begin
                    life_lost_nxt_s = 1'b1;
                    lives_nxt_s     = lives_r - 3'd1;
                    if (lives_r > 3'd1) begin
                        state_nxt_s  = RESUME;
                        timer_load_s = 1'b1;
                        timer_val_s  = RESUME_LOAD;
                    end else begin
                        state_nxt_s = OVER;
                    end
                end else if (dot_eaten) begin
                    if ((dot_r + 10'd1) >= DOT_TGT) begin
                        dot_nxt_s = DOT_TGT;
                        if (level_r < LEVEL_LAST) begin
                            state_nxt_s  = LEVEL_UP;
                            timer_load_s = 1'b1;
                            timer_val_s  = LEVEL_LOAD;
                        end else begin
                            state_nxt_s = WIN;
                        end
                    end else begin
                        dot_nxt_s = dot_r + 10'd1;
                    end
                end else begin
                    state_nxt_s = PLAY;
                end
            end
            RESUME: begin
                if (timer_done_s) begin
                    state_nxt_s = PLAY;
                end else begin
                    state_nxt_s = RESUME;
                end
            end
            LEVEL_UP: begin
                if (timer_done_s) begin
                    state_nxt_s = PLAY;
                    level_nxt_s = level_r + 3'd1;
                    dot_nxt_s   = 10'd0;
                end else begin
                    state_nxt_s = LEVEL_UP;
                end
            end
            OVER, WIN: begin
                if (start_rise_s) begin
                    state_nxt_s = INIT;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = INIT;
            end
        endcase
    end

    // State, counters, pulses and the strobes decoded from the next state.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r        <= INIT;
            lives_r        <= LIVES_LD;
            level_r        <= 3'd1;
            dot_r          <= 10'd0;
            life_lost_r    <= 1'b0;
            ghost_eaten_r  <= {NUM_GHOSTS{1'b0}};
            sprite_reset_r <= 1'b1;
            map_reload_r   <= 1'b1;
            ghost_enable_r <= 1'b0;
            start_r        <= 1'b0;
            hit_r          <= {NUM_GHOSTS{1'b0}};
        end else begin
            state_r        <= state_nxt_s;
            lives_r        <= lives_nxt_s;
            level_r        <= level_nxt_s;
            dot_r          <= dot_nxt_s;
            life_lost_r    <= life_lost_nxt_s;
            ghost_eaten_r  <= ghost_eaten_nxt_s;
            sprite_reset_r <= (state_nxt_s == INIT) || (state_nxt_s == RESUME) ||
                              (state_nxt_s == LEVEL_UP);
            map_reload_r   <= (state_nxt_s == INIT) || (state_nxt_s == LEVEL_UP);
            ghost_enable_r <= (state_nxt_s == PLAY);
            start_r        <= start;
            hit_r          <= hit_s;
        end
    end

    assign state        = state_r;
    assign lives        = lives_r;
    assign level        = level_r;
    assign dot_count    = dot_r;
    assign life_lost    = life_lost_r;
    assign ghost_eaten  = ghost_eaten_r;
    assign sprite_reset = sprite_reset_r;
    assign map_reload   = map_reload_r;
    assign ghost_enable = ghost_enable_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with short freeze times: a vector table
// for single-cycle behaviour plus sequences for death, level, win and reset.
module tb_game_flow_ctrl;
    import pacman_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [5:0]       pacman_x;
    logic [4:0]       pacman_y;
    logic [3:0][5:0]  ghost_x;
    logic [3:0][4:0]  ghost_y;
    logic             power_active;
    logic             dot_eaten;
    game_state_t      state;
    logic [2:0]       lives;
    logic [2:0]       level;
    logic [9:0]       dot_count;
    logic             sprite_reset;
    logic             map_reload;
    logic             ghost_enable;
    logic             life_lost;
    logic [3:0]       ghost_eaten;

    int n_cmp = 0;
    int n_fail = 0;

    game_flow_ctrl #(
        .NUM_GHOSTS    (4),
        .LIVES_INIT    (3),
        .RESUME_CYCLES (8),
        .LEVEL_CYCLES  (4),
        .DOT_TARGET    (5),
        .MAX_LEVEL     (2)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .start        (start),
        .pacman_x     (pacman_x),
        .pacman_y     (pacman_y),
        .ghost_x      (ghost_x),
        .ghost_y      (ghost_y),
        .power_active (power_active),
        .dot_eaten    (dot_eaten),
        .state        (state),
        .lives        (lives),
        .level        (level),
        .dot_count    (dot_count),
        .sprite_reset (sprite_reset),
        .map_reload   (map_reload),
        .ghost_enable (ghost_enable),
        .life_lost    (life_lost),
        .ghost_eaten  (ghost_eaten)
    );

    always #5 clk = ~clk;

    typedef struct {
        int start, power, dot, hit_g;
        int st, lv, lvl, dc, ll, ge, sr, mr, gen;
    } vec_t;

    vec_t tbl[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int lv, input int lvl,
                           input int dc, input int ll, input int ge, input int sr,
                           input int mr, input int gen);
        chk({tag, ".state"},        32'(state),        32'(st));
        chk({tag, ".lives"},        32'(lives),        32'(lv));
        chk({tag, ".level"},        32'(level),        32'(lvl));
        chk({tag, ".dot_count"},    32'(dot_count),    32'(dc));
        chk({tag, ".life_lost"},    32'(life_lost),    32'(ll));
        chk({tag, ".ghost_eaten"},  32'(ghost_eaten),  32'(ge));
        chk({tag, ".sprite_reset"}, 32'(sprite_reset), 32'(sr));
        chk({tag, ".map_reload"},   32'(map_reload),   32'(mr));
        chk({tag, ".ghost_enable"}, 32'(ghost_enable), 32'(gen));
    endtask

    // Park every ghost on its own tile away from pacman, optionally put one on him.
    task automatic place_ghosts(input int hit_g);
        for (int i = 0; i < 4; i++) begin
            ghost_x[i] = 6'(i);
            ghost_y[i] = 5'd0;
        end
        if (hit_g >= 0) begin
            ghost_x[hit_g] = 6'd10;
            ghost_y[hit_g] = 5'd7;
        end
    endtask

    // Cycles 2..8 of a RESUME freeze (a dot is offered in cycle 3), then PLAY.
    task automatic resume_rest(input string tag, input int lv, input int lvl, input int dc);
        for (int c = 2; c <= 8; c++) begin
            dot_eaten = (c == 3);
            step();
            dot_eaten = 1'b0;
            chk({tag, ".frz_state"}, 32'(state), 32'(RESUME));
            chk({tag, ".frz_ll"},    32'(life_lost), 32'd0);
        end
        step();
        chk_all({tag, ".back"}, int'(PLAY), lv, lvl, dc, 0, 0, 0, 0, 1);
    endtask

    task automatic lethal(input int g);
        power_active = 1'b0;
        place_ghosts(g);
        step();
        place_ghosts(-1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pacman_x = 6'd10; pacman_y = 5'd7;
        power_active = 1'b0; dot_eaten = 1'b0;
        place_ghosts(-1);

        tbl[0]  = '{0, 0, 0, -1, int'(INIT), 3, 1, 0, 0, 0, 1, 1, 0};
        tbl[1]  = '{1, 0, 0, -1, int'(PLAY), 3, 1, 0, 0, 0, 0, 0, 1};
        tbl[2]  = '{1, 0, 1, -1, int'(PLAY), 3, 1, 1, 0, 0, 0, 0, 1};
        tbl[3]  = '{1, 0, 0, -1, int'(PLAY), 3, 1, 1, 0, 0, 0, 0, 1};
        tbl[4]  = '{1, 1, 0,  3, int'(PLAY), 3, 1, 1, 0, 8, 0, 0, 1};
        tbl[5]  = '{1, 1, 0,  3, int'(PLAY), 3, 1, 1, 0, 0, 0, 0, 1};
        tbl[6]  = '{1, 1, 0,  3, int'(PLAY), 3, 1, 1, 0, 0, 0, 0, 1};
        tbl[7]  = '{1, 1, 0,  3, int'(PLAY), 3, 1, 1, 0, 0, 0, 0, 1};
        tbl[8]  = '{1, 1, 0,  3, int'(PLAY), 3, 1, 1, 0, 0, 0, 0, 1};
        tbl[9]  = '{1, 1, 0, -1, int'(PLAY), 3, 1, 1, 0, 0, 0, 0, 1};
        tbl[10] = '{1, 1, 0,  0, int'(PLAY), 3, 1, 1, 0, 1, 0, 0, 1};
        tbl[11] = '{1, 0, 1, -1, int'(PLAY), 3, 1, 2, 0, 0, 0, 0, 1};

        // Reset values while reset is held.
        step(); step();
        chk_all("rst", int'(INIT), 3, 1, 0, 0, 0, 1, 1, 0);
        reset = 1'b0;

        // Start, dot counting and power-pill ghost eating.
        for (int k = 0; k < 12; k++) begin
            start        = (tbl[k].start != 0);
            power_active = (tbl[k].power != 0);
            dot_eaten    = (tbl[k].dot != 0);
            place_ghosts(tbl[k].hit_g);
            step();
            chk_all($sformatf("vec%0d", k), tbl[k].st, tbl[k].lv, tbl[k].lvl, tbl[k].dc,
                    tbl[k].ll, tbl[k].ge, tbl[k].sr, tbl[k].mr, tbl[k].gen);
        end
        dot_eaten = 1'b0; power_active = 1'b0; place_ghosts(-1);

        // Lethal hit by ghost 2: eight-clock freeze, dots retained.
        lethal(2);
        chk_all("death1", int'(RESUME), 2, 1, 2, 1, 0, 1, 0, 0);
        resume_rest("death1", 2, 1, 2);

        // Clear level 1, LEVEL_UP for four clocks.
        for (int d = 3; d <= 4; d++) begin
            dot_eaten = 1'b1; step(); dot_eaten = 1'b0;
            chk_all($sformatf("lvl1_dot%0d", d), int'(PLAY), 2, 1, d, 0, 0, 0, 0, 1);
        end
        dot_eaten = 1'b1; step(); dot_eaten = 1'b0;
        chk_all("lvlup1", int'(LEVEL_UP), 2, 1, 5, 0, 0, 1, 1, 0);
        for (int c = 2; c <= 4; c++) begin
            step();
            chk($sformatf("lvlup%0d.state", c), 32'(state), 32'(LEVEL_UP));
        end
        step();
        chk_all("lvl2", int'(PLAY), 2, 2, 0, 0, 0, 0, 0, 1);

        for (int d = 1; d <= 4; d++) begin
            dot_eaten = 1'b1; step(); dot_eaten = 1'b0;
            chk($sformatf("lvl2_dot%0d", d), 32'(dot_count), 32'(d));
        end

        // Final dot together with a lethal hit: death wins, dot dropped.
        dot_eaten = 1'b1;
        lethal(1);
        dot_eaten = 1'b0;
        chk_all("dot_vs_death", int'(RESUME), 1, 2, 4, 1, 0, 1, 0, 0);
        resume_rest("dot_vs_death", 1, 2, 4);

        dot_eaten = 1'b1; step(); dot_eaten = 1'b0;
        chk_all("win", int'(WIN), 1, 2, 5, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("win_hold%0d", c), 32'(state), 32'(WIN));
        end
        start = 1'b0; step();
        chk("win_start0", 32'(state), 32'(WIN));
        start = 1'b1; step();
        chk("win_restart.state", 32'(state), 32'(INIT));
        chk("win_restart.sprite_reset", 32'(sprite_reset), 32'd1);
        chk("win_restart.map_reload", 32'(map_reload), 32'd1);
        chk("win_restart.ghost_enable", 32'(ghost_enable), 32'd0);
        step();
        chk_all("replay1", int'(PLAY), 3, 1, 0, 0, 0, 0, 0, 1);

        // Three deaths to game over.
        lethal(0);
        chk_all("over_h1", int'(RESUME), 2, 1, 0, 1, 0, 1, 0, 0);
        resume_rest("over_h1", 2, 1, 0);
        lethal(3);
        chk_all("over_h2", int'(RESUME), 1, 1, 0, 1, 0, 1, 0, 0);
        resume_rest("over_h2", 1, 1, 0);
        lethal(2);
        chk_all("over_h3", int'(OVER), 0, 1, 0, 1, 0, 0, 0, 0);
        step();
        chk_all("over_hold", int'(OVER), 0, 1, 0, 0, 0, 0, 0, 0);
        step(); step();
        chk("over_start_held", 32'(state), 32'(OVER));
        start = 1'b0; step();
        chk("over_start0", 32'(state), 32'(OVER));
        start = 1'b1; step();
        chk("over_restart", 32'(state), 32'(INIT));
        step();
        chk_all("replay2", int'(PLAY), 3, 1, 0, 0, 0, 0, 0, 1);

        // Reset in the third RESUME clock, then a full clean freeze.
        lethal(1);
        chk("abort_c1", 32'(state), 32'(RESUME));
        step();
        chk("abort_c2", 32'(state), 32'(RESUME));
        step();
        chk("abort_c3", 32'(state), 32'(RESUME));
        reset = 1'b1;
        #1;
        chk_all("abort_rst", int'(INIT), 3, 1, 0, 0, 0, 1, 1, 0);
        step();
        reset = 1'b0;
        step();
        chk_all("abort_play", int'(PLAY), 3, 1, 0, 0, 0, 0, 0, 1);
        lethal(0);
        chk_all("abort_death", int'(RESUME), 2, 1, 0, 1, 0, 1, 0, 0);
        resume_rest("abort_death", 2, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter NUM_GHOSTS, default 4: number of ghost channels checked for collision.
REQ-002 SHALL have parameter LIVES_INIT, default 3: lives loaded on game start.
REQ-003 SHALL have parameter RESUME_CYCLES, default 250000000: post-death freeze length in clocks (must be at least 1).
REQ-004 SHALL have parameter LEVEL_CYCLES, default 100000000: level-transition freeze length in clocks (must be at least 1).
REQ-005 SHALL have parameter DOT_TARGET, default 309: dots eaten that clear a level.
REQ-006 SHALL have parameter MAX_LEVEL, default 4: last playable level.
REQ-007 SHALL have ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level-sensitive game-start switch.
- pacman_x  in  6  pacman tile column.
- pacman_y  in  5  pacman tile row.
- ghost_x  in  NUM_GHOSTS x 6  ghost tile columns.
- ghost_y  in  NUM_GHOSTS x 5  ghost tile rows.
- power_active  in  1  power pill in effect.
- dot_eaten  in  1  one-cycle pulse per dot consumed.
- state  out  3  current game_state_t.
- lives  out  3  remaining lives.
- level  out  3  current level, 1-based.
- dot_count  out  10  dots eaten this level.
- sprite_reset  out  1  return sprites to spawn.
- map_reload  out  1  restore map RAM contents.
- ghost_enable  out  1  ghost AI may move.
- life_lost  out  1  one-cycle pulse on death.
- ghost_eaten  out  NUM_GHOSTS  one-cycle pulse per ghost eaten.

Function
REQ-008 SHALL implement states INIT, PLAY, RESUME, LEVEL_UP, OVER and WIN.
REQ-009 SHALL compute hit[i] as (ghost_x[i]==pacman_x) & (ghost_y[i]==pacman_y), combinationally, for every ghost.
REQ-010 SHALL transition INIT->PLAY when start=1, loading lives=LIVES_INIT, level=1 and dot_count=0.
REQ-011 SHALL, in PLAY, treat any hit[i] with power_active=0 as lethal and assert life_lost for exactly one cycle.
REQ-012 SHALL, on a lethal hit, decrement lives once and go to RESUME if lives>1, or to OVER (lives=0) if lives==1.
REQ-013 SHALL, in PLAY with power_active=1, pulse ghost_eaten[i] for one cycle on the rising edge of hit[i] only, and lose no life.
REQ-014 SHALL increment dot_count on each dot_eaten pulse in PLAY only, saturating at DOT_TARGET.
REQ-015 SHALL, when dot_count reaches DOT_TARGET, go to LEVEL_UP if level<MAX_LEVEL, otherwise to WIN.
REQ-016 SHALL give a lethal hit priority over level completion when both occur in the same cycle, and the dot causing completion is then not counted.
REQ-017 SHALL hold RESUME for exactly RESUME_CYCLES clocks, then return to PLAY with dot_count retained.
REQ-018 SHALL hold LEVEL_UP for exactly LEVEL_CYCLES clocks, then increment level, clear dot_count and return to PLAY.
REQ-019 SHALL leave OVER or WIN and go to INIT only on a 0->1 edge of start; a start held high from before does not restart the game.
REQ-020 SHALL drive sprite_reset=1 in INIT, RESUME and LEVEL_UP; map_reload=1 in INIT and LEVEL_UP; ghost_enable=1 only in PLAY.
REQ-021 SHALL register every output.

Reset
REQ-022 SHALL, on reset, asynchronously force state=INIT, lives=LIVES_INIT, level=1, dot_count=0, all pulses=0, timer=0 and the start and hit edge registers=0.
REQ-023 SHALL let reset abort RESUME or LEVEL_UP mid-count with no residual timer state.

Structure
REQ-024 SHALL take game_state_t, the coordinate widths (6 and 5) and the state encoding from the shared package pacman_pkg.
REQ-025 SHALL place the RESUME/LEVEL_UP countdown in a sub-module freeze_timer, loaded with a count and reporting done.

Verification (NUM_GHOSTS=4, LIVES_INIT=3, RESUME_CYCLES=8, LEVEL_CYCLES=4, DOT_TARGET=5, MAX_LEVEL=2)
REQ-026 SHALL check: start=1, then ghost 2 at pacman tile (10,7), power=0 -> one life_lost pulse, lives 3->2, RESUME for 8 clocks, then PLAY with dot_count unchanged.
REQ-027 SHALL check: power=1 and ghost 3 overlaps pacman for 5 cycles -> a single ghost_eaten[3] pulse, lives unchanged.
REQ-028 SHALL check: 5 dot pulses at level 1 -> LEVEL_UP for 4 clocks, then level=2, dot_count=0; 5 more -> WIN.
REQ-029 SHALL check: 5th dot pulse coincides with a lethal hit -> RESUME, lives decremented, dot_count=4.
REQ-030 SHALL check: three lethal hits -> OVER, lives=0; start held high has no effect; start 0->1 -> INIT, then PLAY with lives=3.
REQ-031 SHALL check: reset asserted in the 3rd RESUME clock -> INIT immediately, with all outputs at their reset values.
